// File: rtl/priority_encoder_8x3_if.sv
// Request/grant bundle for priority_encoder_8x3; the overflow flag exists only
// when ENC_OVERFLOW_EN is defined.
interface priority_encoder_8x3_if;
   logic       en;
   logic [7:0] in;
   logic       ready;
   logic [2:0] out;
   logic       valid;
   logic       busy;
`ifdef ENC_OVERFLOW_EN
   logic       overflow;
`endif

`ifdef ENC_OVERFLOW_EN
   modport master (output en, in, ready, input out, valid, busy, overflow);
   modport slave  (input en, in, ready, output out, valid, busy, overflow);
`else
   modport master (output en, in, ready, input out, valid, busy);
   modport slave  (input en, in, ready, output out, valid, busy);
`endif
endinterface

// File: rtl/priority_encoder_8x3.sv
// Pending-request priority encoder: 8 event lines, bit 7 wins, one code per cycle
// under a valid/ready handshake. Define ENC_OVERFLOW_EN for sticky lost-event detection.
module priority_encoder_8x3 (
   input  logic                   clk,
   input  logic                   rst_n,
   priority_encoder_8x3_if.slave  bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q, state_d;
   logic [7:0] pending_q, pending_d;
   logic [2:0] out_q, out_d;
   logic [7:0] inMasked;
   logic [7:0] cand;
   logic [7:0] clearMask;
   logic [7:0] rem;

   function automatic logic [2:0] winner(input logic [7:0] v);
      logic [2:0] w;
      w = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) w = i[2:0];
      end
      return w;
   endfunction

   // The granted bit is only released on an accept; a same-cycle re-request
   // is ORed back in afterwards so it survives as a fresh event.
   always_comb begin
      inMasked  = bus.en ? bus.in : 8'd0;
      cand      = pending_q | inMasked;
      clearMask = ((state_q == GRANT) && bus.ready) ? (8'd1 << out_q) : 8'd0;
      rem       = (pending_q & ~clearMask) | inMasked;
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      out_d     = out_q;
      unique case (state_q)
         IDLE: begin
            pending_d = cand;
            if (bus.en && (cand != 8'd0)) begin
               out_d   = winner(cand);
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!bus.ready) begin
               pending_d = cand;
            end else begin
               pending_d = rem;
               if (bus.en && (rem != 8'd0)) begin
                  out_d = winner(rem);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= 8'd0;
         out_q     <= 3'd0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         out_q     <= out_d;
      end
   end

   assign bus.out   = out_q;
   assign bus.valid = (state_q == GRANT);
   assign bus.busy  = |pending_q;

`ifdef ENC_OVERFLOW_EN
   logic overflow_q, overflow_d;

   // A second event on a still-pending line is lost, unless that line is being accepted.
   always_comb begin
      overflow_d = overflow_q | (|(inMasked & pending_q & ~clearMask));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_priority_encoder_8x3.sv
// Directed bench for priority_encoder_8x3: expected codes go into a scoreboard
// queue and a monitor pops them on every accepted handshake.
module tb_priority_encoder_8x3;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [2:0] expQ[$];

   priority_encoder_8x3_if bus();

   priority_encoder_8x3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every accepted code must match the oldest expected code.
   always @(negedge clk) begin
      if (rst_n && bus.valid && bus.ready) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_code: got out=%0d with no code expected", bus.out);
         end else begin
            logic [2:0] e;
            e = expQ.pop_front();
            if (bus.out !== e) begin
               errors++;
               $display("[TB] FAIL scoreboard_code: got out=%0d, expected %0d", bus.out, e);
            end
         end
      end
   end

   task automatic applyStimulus(input logic enV, input logic [7:0] inV, input logic readyV);
      bus.en    = enV;
      bus.in    = inV;
      bus.ready = readyV;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);
      #2;
      checkOutput("reset_out",   {5'd0, bus.out}, 8'd0);
      checkOutput("reset_valid", {7'd0, bus.valid}, 8'd0);
      checkOutput("reset_busy",  {7'd0, bus.busy}, 8'd0);
`ifdef ENC_OVERFLOW_EN
      checkOutput("reset_overflow", {7'd0, bus.overflow}, 8'd0);
`endif
      step();
      step();
      rst_n = 1'b1;

      // Single request
      applyStimulus(1'b1, 8'h04, 1'b1);
      expQ.push_back(3'd2);
      step();
      bus.in = 8'h00;
      checkOutput("single_valid", {7'd0, bus.valid}, 8'd1);
      checkOutput("single_out",   {5'd0, bus.out}, 8'd2);
      step();
      checkOutput("single_done_valid", {7'd0, bus.valid}, 8'd0);
      checkOutput("single_done_busy",  {7'd0, bus.busy}, 8'd0);

      // Priority drain 7, 2, 0
      applyStimulus(1'b1, 8'h85, 1'b1);
      expQ.push_back(3'd7);
      expQ.push_back(3'd2);
      expQ.push_back(3'd0);
      step();
      bus.in = 8'h00;
      checkOutput("drain_out7", {5'd0, bus.out}, 8'd7);
      step();
      checkOutput("drain_out2", {5'd0, bus.out}, 8'd2);
      step();
      checkOutput("drain_out0", {5'd0, bus.out}, 8'd0);
      step();
      checkOutput("drain_done_valid", {7'd0, bus.valid}, 8'd0);

      // Backpressure with bits 7 and 3, then bit 6 arrives while held
      applyStimulus(1'b1, 8'h88, 1'b0);
      expQ.push_back(3'd7);
      step();
      bus.in = 8'h00;
      checkOutput("bp_out7",   {5'd0, bus.out}, 8'd7);
      checkOutput("bp_valid",  {7'd0, bus.valid}, 8'd1);
      bus.in = 8'h40;
      step();
      bus.in = 8'h00;
      checkOutput("bp_hold_out", {5'd0, bus.out}, 8'd7);
      checkOutput("bp_hold_busy", {7'd0, bus.busy}, 8'd1);
      step();
      checkOutput("bp_hold2_out", {5'd0, bus.out}, 8'd7);
      bus.ready = 1'b1;
      expQ.push_back(3'd6);
      expQ.push_back(3'd3);
      step();
      checkOutput("bp_out6", {5'd0, bus.out}, 8'd6);
      step();
      checkOutput("bp_out3", {5'd0, bus.out}, 8'd3);
      step();
      checkOutput("bp_done_valid", {7'd0, bus.valid}, 8'd0);

      // Re-request on accept
      applyStimulus(1'b1, 8'h10, 1'b1);
      expQ.push_back(3'd4);
      step();
      bus.in = 8'h10;
      expQ.push_back(3'd4);
      step();
      bus.in = 8'h00;
      checkOutput("rereq_out",   {5'd0, bus.out}, 8'd4);
      checkOutput("rereq_valid", {7'd0, bus.valid}, 8'd1);
      step();
      checkOutput("rereq_done_valid", {7'd0, bus.valid}, 8'd0);
      checkOutput("rereq_done_busy",  {7'd0, bus.busy}, 8'd0);

      // Enable drop during grant: code held, leftover pending kept in IDLE
      applyStimulus(1'b1, 8'h03, 1'b0);
      expQ.push_back(3'd1);
      step();
      checkOutput("en_out1", {5'd0, bus.out}, 8'd1);
      applyStimulus(1'b0, 8'hFF, 1'b0);
      step();
      checkOutput("en_hold_out",   {5'd0, bus.out}, 8'd1);
      checkOutput("en_hold_valid", {7'd0, bus.valid}, 8'd1);
      bus.ready = 1'b1;
      step();
      checkOutput("en_off_valid", {7'd0, bus.valid}, 8'd0);
      checkOutput("en_off_busy",  {7'd0, bus.busy}, 8'd1);
      step();
      checkOutput("en_off2_valid", {7'd0, bus.valid}, 8'd0);
      checkOutput("en_off2_busy",  {7'd0, bus.busy}, 8'd1);
      applyStimulus(1'b1, 8'h00, 1'b1);
      expQ.push_back(3'd0);
      step();
      checkOutput("en_resume_out", {5'd0, bus.out}, 8'd0);
      checkOutput("en_resume_valid", {7'd0, bus.valid}, 8'd1);
      step();
      checkOutput("en_resume_busy", {7'd0, bus.busy}, 8'd0);

      // Reset asserted mid-grant
      applyStimulus(1'b1, 8'hC0, 1'b0);
      step();
      bus.in = 8'h00;
      checkOutput("rst_pre_valid", {7'd0, bus.valid}, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_out",   {5'd0, bus.out}, 8'd0);
      checkOutput("rst_async_valid", {7'd0, bus.valid}, 8'd0);
      checkOutput("rst_async_busy",  {7'd0, bus.busy}, 8'd0);
      step();
      rst_n = 1'b1;
      bus.ready = 1'b1;
      step();
      checkOutput("rst_after_valid", {7'd0, bus.valid}, 8'd0);
      step();
      checkOutput("rst_after_busy", {7'd0, bus.busy}, 8'd0);

`ifdef ENC_OVERFLOW_EN
      // Bit 5 pulsed twice while code 7 is held
      applyStimulus(1'b1, 8'h80, 1'b0);
      expQ.push_back(3'd7);
      step();
      bus.in = 8'h20;
      checkOutput("ovf_clear_before", {7'd0, bus.overflow}, 8'd0);
      step();
      bus.in = 8'h20;
      step();
      bus.in = 8'h00;
      checkOutput("ovf_set",    {7'd0, bus.overflow}, 8'd1);
      checkOutput("ovf_out7",   {5'd0, bus.out}, 8'd7);
      bus.ready = 1'b1;
      expQ.push_back(3'd5);
      step();
      checkOutput("ovf_out5", {5'd0, bus.out}, 8'd5);
      step();
      checkOutput("ovf_drain_valid", {7'd0, bus.valid}, 8'd0);
      checkOutput("ovf_sticky", {7'd0, bus.overflow}, 8'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("ovf_reset", {7'd0, bus.overflow}, 8'd0);
      step();
      rst_n = 1'b1;
`endif

      // Every expected code must have been observed
      for (int i = 0; i < 20 && expQ.size() != 0; i++) step();
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: %0d codes outstanding, expected 0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
